// File: rtl/mem_access_unit.sv
// Memory access responder: aligns MEM-stage loads/stores onto a word bus,
// splitting misaligned accesses into two beats and stalling until done.
module mem_access_unit #(
  parameter int SPLIT_MISALIGNED = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        mem_valid,
  input  logic        mem_we,
  input  logic        mem_re,
  input  logic [1:0]  mem_size,
  input  logic        mem_sign,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        done,
  output logic        misalign,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, DONE} state_t;

  state_t      state_q, state_d;
  logic [1:0]  off_q, off_d;
  logic [1:0]  size_q, size_d;
  logic        sign_q, sign_d;
  logic        we_q, we_d;
  logic [31:0] wdata_q, wdata_d;
  logic [7:0]  smask_q, smask_d;
  logic [31:0] lo_q, lo_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [3:0]  bus_wstrb_q, bus_wstrb_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic        done_q, done_d;
  logic        misalign_q, misalign_d;
  logic [31:0] rdata_q, rdata_d;

  logic        op;
  logic [3:0]  mask_n;
  logic [7:0]  smask_n;
  logic [5:0]  rsh;
  logic [31:0] lo_sh, hi_sh;

  function automatic logic [31:0] ext_f(
    input logic [31:0] r,
    input logic [1:0]  sz,
    input logic        zx
  );
    logic [31:0] v;
    case (sz)
      2'b00:   v = {{24{~zx & r[7]}}, r[7:0]};
      2'b01:   v = {{16{~zx & r[15]}}, r[15:0]};
      default: v = r;
    endcase
    return v;
  endfunction

  assign op = mem_valid & (mem_we | mem_re);
  assign stall = op & (state_q != DONE);

  always_comb begin
    case (mem_size)
      2'b00:   mask_n = 4'b0001;
      2'b01:   mask_n = 4'b0011;
      default: mask_n = 4'b1111;
    endcase
    smask_n = {4'b0000, mask_n} << mem_addr[1:0];
    // Upper-beat shift; only used when off != 0, so never 32.
    rsh   = 6'd32 - {1'b0, off_q, 3'b000};
    lo_sh = bus_rdata >> {off_q, 3'b000};
    hi_sh = bus_rdata << rsh;
  end

  always_comb begin
    state_d     = state_q;
    off_d       = off_q;
    size_d      = size_q;
    sign_d      = sign_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    smask_d     = smask_q;
    lo_d        = lo_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wstrb_d = bus_wstrb_q;
    bus_wdata_d = bus_wdata_q;
    done_d      = 1'b0;
    misalign_d  = 1'b0;
    rdata_d     = rdata_q;
    case (state_q)
      IDLE: begin
        if (op) begin
          off_d   = mem_addr[1:0];
          size_d  = mem_size;
          sign_d  = mem_sign;
          we_d    = mem_we;
          wdata_d = mem_wdata;
          smask_d = smask_n;
          lo_d    = '0;
          if (SPLIT_MISALIGNED == 0 && smask_n[7:4] != 4'b0000) begin
            state_d    = DONE;
            done_d     = 1'b1;
            misalign_d = 1'b1;
            rdata_d    = '0;
          end else begin
            state_d     = BEAT0;
            bus_req_d   = 1'b1;
            bus_we_d    = mem_we;
            bus_addr_d  = {mem_addr[31:2], 2'b00};
            bus_wstrb_d = mem_we ? smask_n[3:0] : 4'b0000;
            bus_wdata_d = mem_wdata << {mem_addr[1:0], 3'b000};
          end
        end
      end
      BEAT0: begin
        if (bus_ack) begin
          lo_d = lo_sh;
          if (smask_q[7:4] != 4'b0000) begin
            state_d     = BEAT1;
            bus_addr_d  = bus_addr_q + 32'd4;
            bus_wstrb_d = we_q ? smask_q[7:4] : 4'b0000;
            bus_wdata_d = wdata_q >> rsh;
          end else begin
            state_d     = DONE;
            bus_req_d   = 1'b0;
            bus_we_d    = 1'b0;
            bus_wstrb_d = 4'b0000;
            done_d      = 1'b1;
            rdata_d     = ext_f(lo_sh, size_q, sign_q);
          end
        end
      end
      BEAT1: begin
        if (bus_ack) begin
          state_d     = DONE;
          bus_req_d   = 1'b0;
          bus_we_d    = 1'b0;
          bus_wstrb_d = 4'b0000;
          done_d      = 1'b1;
          rdata_d     = ext_f(lo_q | hi_sh, size_q, sign_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      off_q       <= '0;
      size_q      <= '0;
      sign_q      <= 1'b0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      smask_q     <= '0;
      lo_q        <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wstrb_q <= '0;
      bus_wdata_q <= '0;
      done_q      <= 1'b0;
      misalign_q  <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      off_q       <= off_d;
      size_q      <= size_d;
      sign_q      <= sign_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      smask_q     <= smask_d;
      lo_q        <= lo_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wstrb_q <= bus_wstrb_d;
      bus_wdata_q <= bus_wdata_d;
      done_q      <= done_d;
      misalign_q  <= misalign_d;
      rdata_q     <= rdata_d;
    end
  end

  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wstrb = bus_wstrb_q;
  assign bus_wdata = bus_wdata_q;
  assign done      = done_q;
  assign misalign  = misalign_q;
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: table of aligned accesses plus split,
// wait-state, reset-abort and reject sequences.
module tb_mem_access_unit;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        mem_valid = 1'b0;
  logic        ns_valid = 1'b0;
  logic        mem_we = 1'b0;
  logic        mem_re = 1'b0;
  logic [1:0]  mem_size = 2'b10;
  logic        mem_sign = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;

  logic        stall, done, misalign, bus_req, bus_we;
  logic [31:0] rdata, bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;

  logic        n_stall, n_done, n_misalign, n_bus_req, n_bus_we;
  logic [31:0] n_rdata, n_bus_addr, n_bus_wdata;
  logic [3:0]  n_bus_wstrb;

  int n_chk = 0;
  int n_fail = 0;

  always #5 CLK = ~CLK;

  mem_access_unit #(.SPLIT_MISALIGNED(1)) dut (
    .CLK(CLK), .RST(RST), .mem_valid(mem_valid), .mem_we(mem_we),
    .mem_re(mem_re), .mem_size(mem_size), .mem_sign(mem_sign),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .stall(stall),
    .rdata(rdata), .done(done), .misalign(misalign),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  mem_access_unit #(.SPLIT_MISALIGNED(0)) dut_ns (
    .CLK(CLK), .RST(RST), .mem_valid(ns_valid), .mem_we(mem_we),
    .mem_re(mem_re), .mem_size(mem_size), .mem_sign(mem_sign),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .stall(n_stall),
    .rdata(n_rdata), .done(n_done), .misalign(n_misalign),
    .bus_req(n_bus_req), .bus_we(n_bus_we), .bus_addr(n_bus_addr),
    .bus_wstrb(n_bus_wstrb), .bus_wdata(n_bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  typedef struct {
    logic        we;
    logic        re;
    logic [1:0]  size;
    logic        sign;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] brd;
    logic [31:0] e_addr;
    logic [3:0]  e_strb;
    logic [31:0] e_wdata;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vt[9];

  task automatic drive(input logic we, input logic re,
                       input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd);
    mem_valid = 1'b1;
    mem_we    = we;
    mem_re    = re;
    mem_size  = sz;
    mem_sign  = sg;
    mem_addr  = a;
    mem_wdata = wd;
  endtask

  task automatic idle_inputs();
    mem_valid = 1'b0;
    ns_valid  = 1'b0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    bus_ack   = 1'b0;
  endtask

  logic [31:0] h_addr, h_wdata;

  initial begin
    vt[0] = '{1'b0, 1'b1, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF,
              32'h100, 4'b0000, 32'h0, 32'hDEADBEEF};
    vt[1] = '{1'b0, 1'b1, 2'b00, 1'b0, 32'h103, 32'h0, 32'h80000000,
              32'h100, 4'b0000, 32'h0, 32'hFFFFFF80};
    vt[2] = '{1'b0, 1'b1, 2'b00, 1'b1, 32'h103, 32'h0, 32'h80000000,
              32'h100, 4'b0000, 32'h0, 32'h00000080};
    vt[3] = '{1'b1, 1'b0, 2'b01, 1'b0, 32'h202, 32'h0000ABCD, 32'h0,
              32'h200, 4'b1100, 32'hABCD0000, 32'h0};
    vt[4] = '{1'b1, 1'b0, 2'b00, 1'b0, 32'h001, 32'h000000A5, 32'h0,
              32'h000, 4'b0010, 32'h0000A500, 32'h0};
    vt[5] = '{1'b0, 1'b1, 2'b01, 1'b1, 32'h102, 32'h0, 32'h80017777,
              32'h100, 4'b0000, 32'h0, 32'h00008001};
    vt[6] = '{1'b0, 1'b1, 2'b01, 1'b0, 32'h102, 32'h0, 32'h80017777,
              32'h100, 4'b0000, 32'h0, 32'hFFFF8001};
    vt[7] = '{1'b0, 1'b1, 2'b11, 1'b0, 32'h010, 32'h0, 32'hCAFEF00D,
              32'h010, 4'b0000, 32'h0, 32'hCAFEF00D};
    vt[8] = '{1'b1, 1'b1, 2'b00, 1'b0, 32'h003, 32'h00000077, 32'h0,
              32'h000, 4'b1000, 32'h77000000, 32'h0};

    repeat (2) @(negedge CLK);
    chk("rst_ctrl", {27'b0, stall, done, misalign, bus_req, bus_we}, 32'h0);
    chk("rst_addr", bus_addr, 32'h0);
    chk("rst_wstrb", {28'b0, bus_wstrb}, 32'h0);
    chk("rst_wdata", bus_wdata, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    RST = 1'b0;
    @(negedge CLK);

    // no-op request: neither we nor re
    drive(1'b0, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
    #1 chk("noop_stall", {31'b0, stall}, 32'h0);
    @(negedge CLK);
    chk("noop_req", {31'b0, bus_req}, 32'h0);
    idle_inputs();

    for (int i = 0; i < 9; i++) begin
      @(negedge CLK);
      drive(vt[i].we, vt[i].re, vt[i].size, vt[i].sign,
            vt[i].addr, vt[i].wdata);
      #1 chk($sformatf("v%0d_stall0", i), {31'b0, stall}, 32'h1);
      @(negedge CLK);
      chk($sformatf("v%0d_req", i), {31'b0, bus_req}, 32'h1);
      chk($sformatf("v%0d_stall1", i), {31'b0, stall}, 32'h1);
      chk($sformatf("v%0d_addr", i), bus_addr, vt[i].e_addr);
      chk($sformatf("v%0d_we", i), {31'b0, bus_we}, {31'b0, vt[i].we});
      chk($sformatf("v%0d_strb", i), {28'b0, bus_wstrb},
          {28'b0, vt[i].e_strb});
      chk($sformatf("v%0d_wdata", i), bus_wdata, vt[i].e_wdata);
      bus_ack = 1'b1;
      bus_rdata = vt[i].brd;
      @(negedge CLK);
      bus_ack = 1'b0;
      chk($sformatf("v%0d_done", i), {31'b0, done}, 32'h1);
      chk($sformatf("v%0d_stall2", i), {31'b0, stall}, 32'h0);
      chk($sformatf("v%0d_dreq", i), {31'b0, bus_req}, 32'h0);
      if (vt[i].re && !vt[i].we)
        chk($sformatf("v%0d_rdata", i), rdata, vt[i].e_rdata);
      idle_inputs();
      @(negedge CLK);
      chk($sformatf("v%0d_done_end", i), {31'b0, done}, 32'h0);
    end

    // split SW at 0x301
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h301, 32'h11223344);
    @(negedge CLK);
    chk("sw_b0_addr", bus_addr, 32'h300);
    chk("sw_b0_strb", {28'b0, bus_wstrb}, 32'hE);
    chk("sw_b0_wdata", bus_wdata, 32'h22334400);
    chk("sw_b0_we", {31'b0, bus_we}, 32'h1);
    bus_ack = 1'b1;
    @(negedge CLK);
    chk("sw_b1_req", {31'b0, bus_req}, 32'h1);
    chk("sw_b1_stall", {31'b0, stall}, 32'h1);
    chk("sw_b1_addr", bus_addr, 32'h304);
    chk("sw_b1_strb", {28'b0, bus_wstrb}, 32'h1);
    chk("sw_b1_wdata", bus_wdata, 32'h00000011);
    @(negedge CLK);
    bus_ack = 1'b0;
    chk("sw_done", {31'b0, done, stall}, 32'h2);
    idle_inputs();
    @(negedge CLK);

    // split LH at 0xFFFFFFFF, wrapping; mem_* scrambled mid-access
    drive(1'b0, 1'b1, 2'b01, 1'b0, 32'hFFFFFFFF, 32'h0);
    @(negedge CLK);
    chk("lh_b0_addr", bus_addr, 32'hFFFFFFFC);
    chk("lh_b0_strb", {28'b0, bus_wstrb}, 32'h0);
    mem_addr = 32'h12345678;
    mem_size = 2'b10;
    mem_sign = 1'b1;
    bus_ack = 1'b1;
    bus_rdata = 32'hAA000000;
    @(negedge CLK);
    chk("lh_b1_addr", bus_addr, 32'h00000000);
    chk("lh_b1_req", {31'b0, bus_req}, 32'h1);
    bus_rdata = 32'h000000BB;
    @(negedge CLK);
    bus_ack = 1'b0;
    chk("lh_done", {31'b0, done}, 32'h1);
    chk("lh_rdata", rdata, 32'hFFFFBBAA);
    idle_inputs();
    @(negedge CLK);

    // LW with 3 wait cycles
    drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h500, 32'h0);
    @(negedge CLK);
    h_addr = bus_addr;
    h_wdata = bus_wdata;
    chk("wait_addr0", h_addr, 32'h500);
    mem_addr = 32'h999;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      chk($sformatf("wait%0d_req", k), {31'b0, bus_req}, 32'h1);
      chk($sformatf("wait%0d_addr", k), bus_addr, h_addr);
      chk($sformatf("wait%0d_wdata", k), bus_wdata, h_wdata);
      chk($sformatf("wait%0d_stall", k), {31'b0, stall, done}, 32'h2);
    end
    bus_ack = 1'b1;
    bus_rdata = 32'h13572468;
    @(negedge CLK);
    bus_ack = 1'b0;
    chk("wait_done", {31'b0, done}, 32'h1);
    chk("wait_rdata", rdata, 32'h13572468);
    idle_inputs();
    @(negedge CLK);

    // reset while waiting on ack
    drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h600, 32'h0);
    @(negedge CLK);
    @(negedge CLK);
    chk("rw_req_pre", {31'b0, bus_req}, 32'h1);
    #2 RST = 1'b1;
    mem_valid = 1'b0;
    #1 chk("rw_req", {31'b0, bus_req}, 32'h0);
    chk("rw_addr", bus_addr, 32'h0);
    @(negedge CLK);
    RST = 1'b0;
    idle_inputs();
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      chk($sformatf("rw_post%0d", k), {30'b0, done, bus_req}, 32'h0);
    end

    // reject misaligned LW on the non-splitting instance
    ns_valid = 1'b1;
    mem_we = 1'b0;
    mem_re = 1'b1;
    mem_size = 2'b10;
    mem_addr = 32'h002;
    #1 chk("ns_stall0", {31'b0, n_stall}, 32'h1);
    @(negedge CLK);
    chk("ns_misalign", {31'b0, n_misalign}, 32'h1);
    chk("ns_done", {31'b0, n_done}, 32'h1);
    chk("ns_req", {31'b0, n_bus_req}, 32'h0);
    chk("ns_stall1", {31'b0, n_stall}, 32'h0);
    chk("ns_rdata", n_rdata, 32'h0);
    idle_inputs();
    @(negedge CLK);
    chk("ns_end", {30'b0, n_misalign, n_bus_req}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
